// File: rtl/maze_pkg.sv
// Shared maze geometry, direction codes, mover FSM states and the
// cell-to-pixel helper used by the player mover.
package maze_pkg;

  localparam int MAZE_COLS   = 10;
  localparam int MAZE_ROWS   = 15;
  localparam int H_WALL_BITS = 160;
  localparam int V_WALL_BITS = 165;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  // Pixel coordinate of a cell edge, truncated to the 9-bit draw bus.
  function automatic logic [8:0] px(
    input int         origin,
    input int         pitch,
    input logic [3:0] idx
  );
    int v;
    v = origin + pitch * int'(idx);
    return v[8:0];
  endfunction

endpackage

// File: rtl/maze_player_mover_if.sv
// Position handshake between the mover (master) and the player draw
// stage (slave): col/row/x/y/at_goal with pos_valid/pos_ack.
interface maze_player_mover_if;

  logic [3:0] col;
  logic [3:0] row;
  logic [8:0] x;
  logic [8:0] y;
  logic       pos_valid;
  logic       pos_ack;
  logic       at_goal;

  modport master (
    output col, row, x, y,
    output pos_valid, at_goal,
    input  pos_ack
  );

  modport slave (
    input  col, row, x, y,
    input  pos_valid, at_goal,
    output pos_ack
  );

endinterface

// File: rtl/button_debounce.sv
// One push-button: 2-flop synchroniser, level debounce and press pulse.
// Ports: clk, rst (sync, high), btn_i raw button, press_o one-cycle press.
// Macro MAZE_MOVER_AUTOREPEAT_EN adds hold-to-repeat press pulses.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_prev_q;

  // Counter runs only while the synced level disagrees with the
  // debounced one; any return to agreement restarts it.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

`ifdef MAZE_MOVER_AUTOREPEAT_EN
  localparam int REP_FIRST = 8000000;
  localparam int REP_NEXT  = 2000000;

  logic [22:0] rep_q, rep_d;
  logic        rep_fire;

  // After a fire the counter reloads so the next one lands
  // REP_NEXT cycles later instead of REP_FIRST.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!db_q) begin
      rep_d = '0;
    end else if (rep_q == 23'(REP_FIRST - 1)) begin
      rep_fire = 1'b1;
      rep_d    = 23'(REP_FIRST - REP_NEXT);
    end else begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  assign press_o = (db_q & ~db_prev_q) | rep_fire;
`else
  assign press_o = db_q & ~db_prev_q;
`endif

endmodule

// File: rtl/maze_player_mover.sv
// Turns four buttons into wall-checked moves on the 10x15 maze and
// hands the new player position to the draw stage.
// Ports: clk, rst (sync, high), btn_up/down/left/right raw buttons,
// h_walls/v_walls wall vectors, pos (master: col,row,x,y,pos_valid,
// at_goal out; pos_ack in). Option: MAZE_MOVER_AUTOREPEAT_EN.
module maze_player_mover
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CELL_PX         = 16,
  parameter int ORIGIN_X        = 0,
  parameter int ORIGIN_Y        = 0,
  parameter int START_COL       = 0,
  parameter int START_ROW       = 0,
  parameter int GOAL_COL        = 9,
  parameter int GOAL_ROW        = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic [H_WALL_BITS-1:0] h_walls,
  input  logic [V_WALL_BITS-1:0] v_walls,
  maze_player_mover_if.master    pos
);

  logic [3:0] btn;
  logic [3:0] press;

  assign btn = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[i]),
      .press_o(press[i])
    );
  end

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;

  logic [7:0] h_top, h_bot;
  logic [7:0] v_lft, v_rgt;
  logic       legal;

  // Bit positions of the four walls around the current cell.
  always_comb begin
    h_top = 8'(159 - 10 * int'(row_q) - int'(col_q));
    h_bot = 8'(149 - 10 * int'(row_q) - int'(col_q));
    v_lft = 8'(164 - 11 * int'(row_q) - int'(col_q));
    v_rgt = 8'(163 - 11 * int'(row_q) - int'(col_q));
  end

  // On-grid test guards the wall read, so border bits never matter.
  always_comb begin
    legal = 1'b0;
    unique case (dir_q)
      DIR_UP:
        legal = (row_q != 4'd0) && !h_walls[h_top];
      DIR_DOWN:
        legal = (row_q < 4'(MAZE_ROWS - 1)) && !h_walls[h_bot];
      DIR_LEFT:
        legal = (col_q != 4'd0) && !v_walls[v_lft];
      DIR_RIGHT:
        legal = (col_q < 4'(MAZE_COLS - 1)) && !v_walls[v_rgt];
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|press) begin
          state_d = ST_CHECK;
          priority case (1'b1)
            press[0]: dir_d = DIR_UP;
            press[1]: dir_d = DIR_DOWN;
            press[2]: dir_d = DIR_LEFT;
            press[3]: dir_d = DIR_RIGHT;
          endcase
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (legal) begin
          state_d = ST_WAIT_ACK;
          unique case (dir_q)
            DIR_UP:    row_d = row_q - 4'd1;
            DIR_DOWN:  row_d = row_q + 4'd1;
            DIR_LEFT:  col_d = col_q - 4'd1;
            DIR_RIGHT: col_d = col_q + 4'd1;
          endcase
        end
      end
      ST_WAIT_ACK: begin
        if (pos.pos_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    x_d = px(ORIGIN_X, CELL_PX, col_d);
    y_d = px(ORIGIN_Y, CELL_PX, row_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_ACK;
      dir_q   <= DIR_UP;
      col_q   <= 4'(START_COL);
      row_q   <= 4'(START_ROW);
      x_q     <= px(ORIGIN_X, CELL_PX, 4'(START_COL));
      y_q     <= px(ORIGIN_Y, CELL_PX, 4'(START_ROW));
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign pos.col       = col_q;
  assign pos.row       = row_q;
  assign pos.x         = x_q;
  assign pos.y         = y_q;
  assign pos.pos_valid = (state_q == ST_WAIT_ACK);
  assign pos.at_goal   = (col_q == 4'(GOAL_COL)) &&
                         (row_q == 4'(GOAL_ROW));

endmodule

// File: tb/tb_maze_player_mover.sv
// Bench for maze_player_mover: grid-level model of position, handshake
// and goal, compared every cycle, plus directed and random moves.
module tb_maze_player_mover;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_up, btn_down, btn_left, btn_right;
  logic [159:0] h_walls;
  logic [164:0] v_walls;

  maze_player_mover_if pif();

  maze_player_mover #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .h_walls  (h_walls),
    .v_walls  (v_walls),
    .pos      (pif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit hw [16][10];
  bit vw [15][11];

  int exp_col, exp_row;
  bit exp_valid;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic compare();
    chk("col", int'(pif.col), exp_col);
    chk("row", int'(pif.row), exp_row);
    chk("x", int'(pif.x), (exp_col * 16) % 512);
    chk("y", int'(pif.y), (exp_row * 16) % 512);
    chk("pos_valid", int'(pif.pos_valid), int'(exp_valid));
    chk("at_goal", int'(pif.at_goal),
        int'(exp_col == 9 && exp_row == 14));
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) compare();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_walls();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 10; c++)
        h_walls[159 - 10 * r - c] = hw[r][c];
    for (int r = 0; r < 15; r++)
      for (int l = 0; l < 11; l++)
        v_walls[164 - 11 * r - l] = vw[r][l];
  endtask

  task automatic clear_walls();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 10; c++) hw[r][c] = 1'b0;
    for (int r = 0; r < 15; r++)
      for (int l = 0; l < 11; l++) vw[r][l] = 1'b0;
  endtask

  function automatic bit can_move(input int d, input int c,
                                  input int r);
    case (d)
      0: return r > 0  && !hw[r][c];
      1: return r < 14 && !hw[r + 1][c];
      2: return c > 0  && !vw[r][c];
      default: return c < 9 && !vw[r][c + 1];
    endcase
  endfunction

  // mask bit 0 up, 1 down, 2 left, 3 right
  task automatic press(input bit [3:0] mask);
    bit busy;
    int d;
    busy = exp_valid;
    d = -1;
    for (int i = 3; i >= 0; i--) if (mask[i]) d = i;
    btn_up    = mask[0];
    btn_down  = mask[1];
    btn_left  = mask[2];
    btn_right = mask[3];
    repeat (N + 4) step();
    if (!busy && d >= 0 && can_move(d, exp_col, exp_row)) begin
      case (d)
        0: exp_row--;
        1: exp_row++;
        2: exp_col--;
        default: exp_col++;
      endcase
      exp_valid = 1'b1;
    end
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    repeat (2 * N + 6) step();
  endtask

  task automatic ack();
    pif.pos_ack = 1'b1;
    step();
    exp_valid = 1'b0;
    pif.pos_ack = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    exp_col = 0;
    exp_row = 0;
    exp_valid = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    pif.pos_ack = 1'b0;
    clear_walls();
    for (int c = 0; c < 10; c++) hw[0][c] = 1'b1;
    vw[0][0] = 1'b1;
    vw[1][1] = 1'b1;
    pack_walls();
    @(posedge clk); #1;
    step();
    do_reset();
    chk_en = 1'b1;
    step();
    chk("rst_valid", int'(pif.pos_valid), 1);
    chk("rst_x", int'(pif.x), 0);
    chk("rst_y", int'(pif.y), 0);
    chk("rst_goal", int'(pif.at_goal), 0);

    ack();
    chk("ack_valid", int'(pif.pos_valid), 0);

    press(4'b0001);
    chk("up_off_row", int'(pif.row), 0);
    chk("up_off_valid", int'(pif.pos_valid), 0);

    press(4'b1000);
    chk("right_col", int'(pif.col), 1);
    chk("right_x", int'(pif.x), 16);
    ack();
    press(4'b0100);
    chk("left_col", int'(pif.col), 0);
    ack();
    press(4'b0010);
    chk("down_row", int'(pif.row), 1);
    chk("down_y", int'(pif.y), 16);
    ack();
    press(4'b1000);
    chk("blocked_col", int'(pif.col), 0);
    press(4'b1001);
    chk("prio_row", int'(pif.row), 0);
    chk("prio_col", int'(pif.col), 0);
    ack();

    press(4'b1000);
    press(4'b0010);
    chk("drop_row", int'(pif.row), 0);
    chk("drop_col", int'(pif.col), 1);
    ack();

    btn_left = 1'b1;
    repeat (N - 1) step();
    btn_left = 1'b0;
    repeat (3 * N + 10) step();
    chk("bounce_col", int'(pif.col), 1);

    press(4'b0010);
    chk("pend_row", int'(pif.row), 1);
    do_reset();
    step();
    chk("rst2_col", int'(pif.col), 0);
    chk("rst2_row", int'(pif.row), 0);
    chk("rst2_valid", int'(pif.pos_valid), 1);
    ack();

    for (int k = 0; k < 60; k++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 10; c++)
          hw[r][c] = ($urandom_range(3) == 0);
      for (int r = 0; r < 15; r++)
        for (int l = 0; l < 11; l++)
          vw[r][l] = ($urandom_range(3) == 0);
      pack_walls();
      if ($urandom_range(9) < 7) ack();
      if ($urandom_range(4) == 0)
        press(4'($urandom_range(15)));
      else
        press(4'b0001 << $urandom_range(3));
    end

    clear_walls();
    pack_walls();
    ack();
    while (exp_col < 9) begin press(4'b1000); ack(); end
    while (exp_row < 14) begin press(4'b0010); ack(); end
    chk("goal", int'(pif.at_goal), 1);
    chk("goal_x", int'(pif.x), 144);
    chk("goal_y", int'(pif.y), 224);
    press(4'b1000);
    press(4'b0010);
    chk("edge_col", int'(pif.col), 9);
    chk("edge_row", int'(pif.row), 14);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_player_mover.md
Name: maze_player_mover

Overview:
- Converts four push-buttons into player moves on the 10-column x 15-row maze grid.
- Checks each requested step against the wall vectors that feed scene_exhibitor.
- Commits legal moves and presents the player's pixel coordinates to the player draw stage, using a valid/ack handshake.
- Sits upstream of player; replaces the constant x/y currently tied into it.

Parameters:
- DEBOUNCE_CYCLES, 250000: stable-level cycles needed before a button press is accepted.
- CELL_PX, 16: cell pitch in pixels.
- ORIGIN_X, 0: pixel x of column 0.
- ORIGIN_Y, 0: pixel y of row 0.
- START_COL, 0: column after reset.
- START_ROW, 0: row after reset.
- GOAL_COL, 9: goal cell column.
- GOAL_ROW, 14: goal cell row.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high.
- h_walls  in  160  16 horizontal wall lines x 10 cells. Line r (0 = top) occupies bits [159-10r -: 10]; column c is at bit 159-10r-c.
- v_walls  in  165  15 rows x 11 vertical wall lines. Row r occupies bits [164-11r -: 11]; line l (0 = left) is at bit 164-11r-l.
- col  out  4  current column, 0..9.
- row  out  4  current row, 0..14.
- x  out  9  ORIGIN_X + col*CELL_PX.
- y  out  9  ORIGIN_Y + row*CELL_PX.
- pos_valid  out  1  new position awaiting redraw.
- pos_ack  in  1  draw stage has consumed the position.
- at_goal  out  1  high while col == GOAL_COL and row == GOAL_ROW.

Behaviour:
- Reset (rst high at posedge):
  - col = START_COL, row = START_ROW; x and y follow.
  - pos_valid = 1, so the start position is drawn once.
  - at_goal reflects the reset position.
  - Synchronisers and debounce counters cleared; FSM in WAIT_ACK.
  - A reset mid-handshake abandons the pending move.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - 18-bit counter (sized with $clog2) restarts on any level change.
  - Debounced level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a one-cycle pulse on the debounced rising edge.
- FSM states:
  - IDLE: on any press event, latch the direction and go to CHECK. If several press events occur in the same cycle, priority is up > down > left > right and the others are discarded.
  - CHECK (exactly 1 cycle): legal when the target is on-grid and the crossed wall bit is 0.
    - up: row > 0 and h line row, column col, is 0.
    - down: row < 14 and h line row+1 is 0.
    - left: col > 0 and v line col, row row, is 0.
    - right: col < 9 and v line col+1 is 0.
    - Legal: update col/row, assert pos_valid, go to WAIT_ACK.
    - Illegal: no change, return to IDLE.
  - WAIT_ACK: hold pos_valid and x/y stable until pos_ack=1 at a posedge, then clear pos_valid and go to IDLE. Press events arriving in WAIT_ACK are dropped; there is no queue.
- Latency: press event to updated col/row/pos_valid is 2 cycles.
- x/y timing: registered, updated in the same cycle as col/row. Multiply by CELL_PX is a shift when CELL_PX is a power of two; widths are truncated to 9 bits.
- Boundary cells: the on-grid check overrides wall bits, so outer-edge wall bits are ignored for off-grid moves.
- pos_ack outside WAIT_ACK: ignored.
- at_goal: combinational from registered col/row.

Optional Feature:
- Macro: MAZE_MOVER_AUTOREPEAT_EN.
- When defined: a button held debounced-high for 8,000,000 cycles generates a repeat press event, then another every 2,000,000 cycles while it stays held. Repeats follow the same priority and drop rules as ordinary presses.
- When undefined: one move per press; the repeat counters are not synthesised.

Decomposition:
- Package maze_pkg:
  - MAZE_COLS=10, MAZE_ROWS=15.
  - H_WALL_BITS=160, V_WALL_BITS=165.
  - Direction enum DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT (2 bits).
  - FSM state constants.
- Sub-module button_debounce: synchroniser, debounce and press-pulse generation, plus auto-repeat under the macro. Instantiated four times.

Test Plan:
- Reset with START 0,0: pos_valid=1, x=0, y=0; pos_ack pulse -> pos_valid=0, FSM in IDLE.
- Wall checks, test maze from top level, DEBOUNCE_CYCLES=4:
  - right at (0,0), v row 0 line 1 = 0 -> col=1, x=16 two cycles after the press pulse.
  - down at (0,0), h line 1 col 0 = 0 -> row=1.
  - up at (0,0), off-grid -> no change.
  - right from (0,1), v row 1 line 1 = 1 -> blocked.
- Simultaneous up and right presses at (0,1): right is discarded; up is legal -> row=0, col=0.
- Press during WAIT_ACK with pos_ack held low: position unchanged, press dropped.
- Bounce of 3 cycles (< DEBOUNCE_CYCLES) on btn_left -> no move.
- Goal: walk to (9,14) -> at_goal=1.
- Assert rst while in WAIT_ACK -> START position restored, pos_valid=1.
